// File: rtl/de_pkg.sv
// Shared types and constants for the Difference Engine result display.
`default_nettype none

package de_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low gfedcba codes with dp off; element 0 is the code for digit 0.
  localparam logic [9:0][7:0] SEG_CODES = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

`default_nettype wire

// File: rtl/de_result_display_bcd_to_sseg.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
`default_nettype none

module bcd_to_sseg
  import de_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] seg
);

  // Codes above 9 cannot come out of the converter; show them blank anyway.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      seg = SEG_CODES[bcd];
    end
  end

endmodule

`default_nettype wire

// File: rtl/de_result_display.sv
// Captures engine results, converts them to BCD by shift/add-3 and scans
// them onto a 4-digit multiplexed seven-segment display.
`default_nettype none

module de_result_display
  import de_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int REFRESH_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              done_tick,
  output logic [3:0]        an,
  output logic [7:0]        sseg,
  output logic              busy,
  output logic              valid
);

  localparam int         BCD_W    = 4 * NUM_DIGITS;
  localparam logic [3:0] CNT_INIT = 4'(DATA_W);

  state_t                    state_q, state_d;
  logic [DATA_W-1:0]         bin_q, bin_d;
  logic [BCD_W-1:0]          bcd_q, bcd_d;
  logic [BCD_W-1:0]          disp_q, disp_d;
  logic [3:0]                count_q, count_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;
  logic [REFRESH_W-1:0]      refresh_q, refresh_d;
  logic [3:0]                an_q, an_d;
  logic [7:0]                sseg_q, sseg_d;

  logic [BCD_W-1:0]          bcd_adj;
  logic [BCD_W+DATA_W-1:0]   shifted;
  logic [1:0]                sel;
  logic [3:0]                digit;
  logic [NUM_DIGITS-1:0]     lead_blank;
  logic [7:0]                dec_seg;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    assign bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
  end

  assign shifted = {bcd_adj, bin_q} << 1;

  // A new done_tick always wins, even on the commit cycle, so a stale
  // in-flight conversion can never reach the display.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    disp_d  = disp_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    if (done_tick) begin
      bin_d   = data_in;
      bcd_d   = '0;
      count_d = CNT_INIT;
      state_d = CONV;
      busy_d  = 1'b1;
    end else if (state_q == CONV) begin
      bcd_d   = shifted[BCD_W+DATA_W-1:DATA_W];
      bin_d   = shifted[DATA_W-1:0];
      count_d = count_q - 4'd1;
      if (count_q == 4'd1) begin
        disp_d  = shifted[BCD_W+DATA_W-1:DATA_W];
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  assign sel   = refresh_q[REFRESH_W-1 -: 2];
  assign digit = disp_q[4*sel +: 4];

  // Blank every digit above the most significant nonzero one; digit 0 stays.
  always_comb begin
    logic all_zero;
    lead_blank = '0;
    all_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero && (disp_q[4*i +: 4] == 4'd0);
      lead_blank[i] = all_zero;
    end
  end

  bcd_to_sseg u_dec (
    .bcd   (digit),
    .blank (lead_blank[sel]),
    .seg   (dec_seg)
  );

  always_comb begin
    refresh_d = refresh_q + REFRESH_W'(1);
    an_d      = ~(4'b0001 << sel);
    sseg_d    = valid_q ? dec_seg : SEG_DASH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      refresh_q <= '0;
      an_q      <= 4'b1111;
      sseg_q    <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      disp_q    <= disp_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      refresh_q <= refresh_d;
      an_q      <= an_d;
      sseg_q    <= sseg_d;
    end
  end

  assign an    = an_q;
  assign sseg  = sseg_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_de_result_display.sv
// Directed bench for de_result_display: conversion table plus restart/reset sequences.
`default_nettype none

module tb_de_result_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic       done_tick = 1'b0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       busy;
  logic       valid;

  int total = 0;
  int bad   = 0;

  de_result_display #(.DATA_W(8), .REFRESH_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .done_tick (done_tick),
    .an        (an),
    .sseg      (sseg),
    .busy      (busy),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    logic [7:0] d0, d1, d2, d3;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Collect one sseg sample per digit over a full 16-cycle scan.
  task automatic read_digits(output logic [7:0] d0, output logic [7:0] d1,
                             output logic [7:0] d2, output logic [7:0] d3);
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: d0 = sseg;
        4'b1101: d1 = sseg;
        4'b1011: d2 = sseg;
        4'b0111: d3 = sseg;
        default: ;
      endcase
    end
  endtask

  task automatic chk_digits(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] d0, d1, d2, d3;
    read_digits(d0, d1, d2, d3);
    chk({tag, " d0"}, 32'(d0), 32'(e0));
    chk({tag, " d1"}, 32'(d1), 32'(e1));
    chk({tag, " d2"}, 32'(d2), 32'(e2));
    chk({tag, " d3"}, 32'(d3), 32'(e3));
  endtask

  // Called at a negedge; the pulse is captured on the next posedge (E0).
  task automatic pulse(input logic [7:0] v);
    data_in   = v;
    done_tick = 1'b1;
    @(negedge clk);
    done_tick = 1'b0;
  endtask

  task automatic convert(input logic [7:0] v, input string tag);
    pulse(v);
    chk({tag, " busy E0"}, 32'(busy), 32'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk({tag, " busy mid"}, 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk({tag, " busy commit"}, 32'(busy), 32'd0);
    chk({tag, " valid commit"}, 32'(valid), 32'd1);
  endtask

  function automatic logic [3:0] an_exp(input int k);
    logic [3:0] t;
    t = 4'b0001 << (k % 4);
    return ~t;
  endfunction

  initial begin
    logic [3:0] prev;
    int         guard;

    vecs[0] = '{8'd255, 8'h92, 8'h92, 8'hA4, 8'hFF};
    vecs[1] = '{8'd0,   8'hC0, 8'hFF, 8'hFF, 8'hFF};
    vecs[2] = '{8'd100, 8'hC0, 8'hC0, 8'hF9, 8'hFF};
    vecs[3] = '{8'd7,   8'hF8, 8'hFF, 8'hFF, 8'hFF};
    vecs[4] = '{8'd45,  8'h92, 8'h99, 8'hFF, 8'hFF};
    vecs[5] = '{8'd200, 8'hC0, 8'hC0, 8'hA4, 8'hFF};
    vecs[6] = '{8'd109, 8'h90, 8'hC0, 8'hF9, 8'hFF};
    vecs[7] = '{8'd80,  8'hC0, 8'h80, 8'hFF, 8'hFF};

    // Reset values while held
    repeat (3) @(negedge clk);
    chk("rst an", 32'(an), 32'hF);
    chk("rst sseg", 32'(sseg), 32'hFF);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    reset = 1'b1;
    chk_digits("dash", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    // Scan: sync to the first cycle of digit 0, then follow 64 cycles
    prev  = an;
    guard = 0;
    @(negedge clk);
    while (!(an == 4'b1110 && prev != 4'b1110) && guard < 32) begin
      prev = an;
      @(negedge clk);
      guard++;
    end
    chk("scan sync", 32'(guard < 32), 32'd1);
    for (int i = 0; i < 64; i++) begin
      chk("scan an", 32'(an), 32'(an_exp(i / 4)));
      @(negedge clk);
    end

    for (int v = 0; v < 8; v++) begin
      convert(vecs[v].val, $sformatf("vec%0d", vecs[v].val));
      @(negedge clk);
      chk_digits($sformatf("vec%0d", vecs[v].val), vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3);
    end

    // Restart: 37 aborted by 100 on the 4th CONV cycle
    pulse(8'd37);
    chk("rs busy E0", 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("rs busy pre", 32'(busy), 32'd1);
    end
    pulse(8'd100);
    chk("rs busy E4", 32'(busy), 32'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("rs busy post", 32'(busy), 32'd1);
      if (an == 4'b1110) chk("rs hold d0", 32'(sseg), 32'hC0);
      if (an == 4'b1101) chk("rs hold d1", 32'(sseg), 32'h80);
    end
    @(negedge clk);
    chk("rs busy commit", 32'(busy), 32'd0);
    @(negedge clk);
    chk_digits("rs", 8'hC0, 8'hC0, 8'hF9, 8'hFF);

    // Restart on the commit cycle: 37 replaced by 45 on its 8th edge
    pulse(8'd37);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
    end
    chk("rc busy E7", 32'(busy), 32'd1);
    pulse(8'd45);
    chk("rc busy E8", 32'(busy), 32'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (an == 4'b1101) chk("rc hold d1", 32'(sseg), 32'hC0);
    end
    @(negedge clk);
    chk("rc busy commit", 32'(busy), 32'd0);
    @(negedge clk);
    chk_digits("rc", 8'h92, 8'h99, 8'hFF, 8'hFF);

    // Reset during cycle 3 of a conversion
    pulse(8'd200);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr an", 32'(an), 32'hF);
    chk("mr sseg", 32'(sseg), 32'hFF);
    chk("mr busy", 32'(busy), 32'd0);
    chk("mr valid", 32'(valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk_digits("mr dash", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    chk("mr valid after", 32'(valid), 32'd0);
    chk("mr busy after", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/de_result_display.md
Name: de_result_display

Overview:
- Result consumer for the Difference Engine's data_out/done_tick handshake; the engine drives this block.
- On each done_tick it captures the engine result and converts it sequentially from binary to BCD with shift/add-3.
- It drives the board's 4-digit multiplexed seven-segment display through an/sseg.
- Sits in the FPGA top level beside the engine; takes over the LED-only result output.

Parameters:
- DATA_W, 8: width of data_in; legal range 1..13, so the result fits 4 BCD digits.
- REFRESH_W, 18: width of the free-running refresh counter; its top 2 bits select the digit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  engine result; sampled only when done_tick=1
- done_tick  in  1  one-cycle pulse from the engine marking data_in valid
- an  out  4  digit enables, active-low; an[0] = rightmost digit
- sseg  out  8  segments, active-low; [6:0]=gfedcba, [7]=dp
- busy  out  1  conversion in progress
- valid  out  1  at least one result committed since reset; sticky

Behaviour:
- Reset (reset=0, async) values:
  - an=4'b1111, sseg=8'hFF, busy=0, valid=0.
  - Refresh counter=0, FSM=IDLE, display register cleared.
- FSM states: IDLE and CONV.
- Capture edge (done_tick=1, any state):
  - bin_reg<=data_in, bcd_reg<=0, iteration count<=DATA_W, state<=CONV, busy<=1.
- CONV, each cycle:
  - Every BCD nibble >=5 gets +3.
  - Then {bcd_reg,bin_reg} shifts left 1; count decrements.
- Commit, on the edge where count goes 1->0:
  - The shifted BCD value is written to disp_bcd; valid<=1, busy<=0, state<=IDLE.
  - Latency: disp_bcd updates on the DATA_W-th edge after the capture edge.
- Display stability: disp_bcd changes only at commit. The previous value stays shown during CONV.
- done_tick during CONV, including the commit cycle: abort and restart with the new data_in. Latest result wins; the in-flight result is never committed.
- Refresh counter: free-running, wraps modulo 2^REFRESH_W. sel = counter[REFRESH_W-1:REFRESH_W-2].
  - sel=0 -> an=1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
- an and sseg are registered, lagging sel by one cycle; they are glitch-free.
- Segment codes (dp off, sseg[7]=1 always):
  - Digits 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90.
  - Dash = BF; blank = FF.
- valid=0: all four digits show dash.
- valid=1: leading-zero blanking applies. Digits above the most significant nonzero digit are blank. Digit 0 is always shown.
- BCD nibbles >9 cannot occur; the decoder maps them to blank.
- Reset mid-conversion: immediate abort to reset values; the display returns to dashes.

Decomposition:
- Shared package de_pkg holds:
  - State enum {IDLE, CONV}.
  - Segment constants SEG_DASH=8'hBF, SEG_BLANK=8'hFF, and the 0..9 code table.
  - NUM_DIGITS=4.
- One natural sub-module: bcd_to_sseg, a combinational 4-bit BCD to 8-bit active-low segment decoder with a blank input.
- The FSM, converter and scan logic stay in de_result_display.

Test Plan (REFRESH_W=4 in sim, so each digit is held 4 cycles):
- Reset:
  - Hold reset=0 -> an=1111, sseg=FF, busy=0, valid=0.
  - Release -> every digit shows BF as an cycles 1110,1101,1011,0111.
- Scan:
  - Run 64 cycles idle -> an sequence repeats every 16 cycles, each value held exactly 4 cycles, and wraps cleanly.
- 255:
  - done_tick with data_in=8'd255 -> busy=1 for 8 cycles; valid and commit on the 8th edge.
  - Digits: d0=92, d1=92, d2=A4, d3=FF.
- 0:
  - data_in=8'd0 -> d0=C0; d1, d2 and d3 all FF.
- Restart:
  - data_in=37, then done_tick with data_in=100 on the 4th CONV cycle -> 37 is never displayed.
  - Commit 8 edges after the second pulse; digits d0=C0, d1=C0, d2=F9, d3=FF.
  - A done_tick on the commit cycle also restarts the conversion.
- Reset mid-CONV:
  - Assert reset during cycle 3 of a conversion -> outputs at reset values immediately.
  - After release, dashes until the next done_tick.
